ncl_qadd_sequencer: RTL

- Clocked front-end controller for a multi-digit quaternary NCL ripple adder built from 1-of-4 digit full adders.
- Accepts binary operands over a valid/ready interface and encodes them into 1-of-4 DATA wavefronts.
- Sequences the four-phase DATA/NULL protocol against the adder's completion and acknowledge signals, then decodes the result and returns it over a second valid/ready interface.
- Used as the stimulus and measurement harness for 2D-pipelined adder experiments.

---
 rtl/ncl_qadd_sequencer_if.sv | 34 +++
 rtl/ncl_qadd_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ncl_qadd_sequencer_if.sv
// Bus between the NCL quaternary adder sequencer and its environment: operand and result
// valid/ready handshakes plus the 1-of-4 adder-facing wavefront signals.
interface ncl_qadd_sequencer_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*DIGITS-1:0]   a_bin;
    logic [2*DIGITS-1:0]   b_bin;
    logic                  cin_bin;
    logic [4*DIGITS-1:0]   aq;
    logic [4*DIGITS-1:0]   bq;
    logic [1:0]            cq;
    logic                  ab_comp;
    logic [4*DIGITS-1:0]   sumq;
    logic [1:0]            carryq;
    logic                  sum_comp;
    logic                  carry_comp;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DIGITS-1:0]   sum_bin;
    logic                  cout_bin;
    logic                  err;

    modport slave (
        input  in_valid, a_bin, b_bin, cin_bin, ab_comp, sumq, carryq, out_ready,
        output in_ready, aq, bq, cq, sum_comp, carry_comp, out_valid, sum_bin, cout_bin, err
    );

    modport master (
        output in_valid, a_bin, b_bin, cin_bin, ab_comp, sumq, carryq, out_ready,
        input  in_ready, aq, bq, cq, sum_comp, carry_comp, out_valid, sum_bin, cout_bin, err
    );
endinterface

// File: rtl/ncl_qadd_sequencer.sv
// Clocked front-end for a quaternary NCL ripple adder: encodes binary operands to 1-of-4
// wavefronts, sequences DATA/NULL against adder completion and decodes the result.
module ncl_qadd_sequencer #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic                 clk,
    input logic                 init,
    ncl_qadd_sequencer_if.slave bus
);

    localparam int unsigned W          = 2 * DIGITS;
    localparam int unsigned Q          = 4 * DIGITS;
    localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StNullw,
        StDone,
        StErr
    } state_e;

    state_e           r_state, w_state_d;
    logic [7:0]       r_cnt, w_cnt_d;
    logic [W-1:0]     r_a, r_b, w_a_d, w_b_d;
    logic             r_cin, w_cin_d;
    logic             w_accept;
    logic [W-1:0]     r_sum_bin;
    logic             r_cout_bin;
    logic [Q-1:0]     r_aq, r_bq, w_aq_d, w_bq_d;
    logic [1:0]       r_cq, w_cq_d;
    logic             r_comp, w_comp_d;

    logic [SYNC_STAGES-1:0] r_ab_sync;
    logic [Q-1:0]           r_sum_sync [SYNC_STAGES];
    logic [1:0]             r_car_sync [SYNC_STAGES];
    logic                   w_ab_s;
    logic [Q-1:0]           w_sum_s;
    logic [1:0]             w_car_s;

    logic             w_data_ok, w_null_ok, w_inv;
    logic             r_data_ok, r_null_ok, r_inv;
    logic             w_data_met, w_null_met, w_inv_met, w_timeout;
    logic [W-1:0]     w_sum_dec;

    function automatic logic [Q-1:0] encode(input logic [W-1:0] v);
        logic [Q-1:0] q;
        q = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            q[4*i +: 4] = 4'b0001 << v[2*i +: 2];
        end
        return q;
    endfunction

    function automatic logic [1:0] decode_digit(input logic [3:0] d);
        return {d[3] | d[2], d[3] | d[1]};
    endfunction

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            r_ab_sync <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sum_sync[i] <= '0;
                r_car_sync[i] <= '0;
            end
        end else begin
            r_ab_sync     <= {r_ab_sync[SYNC_STAGES-2:0], bus.ab_comp};
            r_sum_sync[0] <= bus.sumq;
            r_car_sync[0] <= bus.carryq;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sum_sync[i] <= r_sum_sync[i-1];
                r_car_sync[i] <= r_car_sync[i-1];
            end
        end
    end

    assign w_ab_s  = r_ab_sync[SYNC_STAGES-1];
    assign w_sum_s = r_sum_sync[SYNC_STAGES-1];
    assign w_car_s = r_car_sync[SYNC_STAGES-1];

    always_comb begin
        w_data_ok = w_ab_s && ($countones(w_car_s) == 1);
        w_null_ok = !w_ab_s && (w_car_s == 2'b00);
        w_inv     = (w_car_s == 2'b11);
        w_sum_dec = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ($countones(w_sum_s[4*i +: 4]) != 1) w_data_ok = 1'b0;
            if (w_sum_s[4*i +: 4] != 4'b0000)       w_null_ok = 1'b0;
            if ($countones(w_sum_s[4*i +: 4]) > 1)  w_inv     = 1'b1;
            w_sum_dec[2*i +: 2] = decode_digit(w_sum_s[4*i +: 4]);
        end
    end

    // Each condition must hold on two consecutive synchronized samples to ride out digit skew.
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            r_data_ok <= 1'b0;
            r_null_ok <= 1'b0;
            r_inv     <= 1'b0;
        end else begin
            r_data_ok <= w_data_ok;
            r_null_ok <= w_null_ok;
            r_inv     <= w_inv;
        end
    end

    assign w_data_met = w_data_ok && r_data_ok;
    assign w_null_met = w_null_ok && r_null_ok;
    assign w_inv_met  = w_inv && r_inv;
    assign w_timeout  = (r_cnt >= TimeoutCnt);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: if (bus.in_valid) w_state_d = StData;
            StData: begin
                if (w_inv_met || w_timeout) w_state_d = StErr;
                else if (w_data_met)        w_state_d = StNullw;
            end
            StNullw: begin
                if (w_inv_met || w_timeout) w_state_d = StErr;
                else if (w_null_met)        w_state_d = StDone;
            end
            StDone:  if (bus.out_ready) w_state_d = StIdle;
            StErr:   w_state_d = StErr;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_accept = (r_state == StIdle) && bus.in_valid;
        w_a_d    = w_accept ? bus.a_bin : r_a;
        w_b_d    = w_accept ? bus.b_bin : r_b;
        w_cin_d  = w_accept ? bus.cin_bin : r_cin;

        w_cnt_d = r_cnt;
        if (w_state_d != r_state) begin
            w_cnt_d = '0;
        end else if ((r_state == StData || r_state == StNullw) && r_cnt != 8'hFF) begin
            w_cnt_d = r_cnt + 8'd1;
        end

        // Adder-facing wavefronts are registered so the async adder never sees decode glitches.
        w_aq_d = '0;
        w_bq_d = '0;
        w_cq_d = '0;
        if (w_state_d == StData) begin
            w_aq_d = encode(w_a_d);
            w_bq_d = encode(w_b_d);
            w_cq_d = w_cin_d ? 2'b10 : 2'b01;
        end
        w_comp_d = (w_state_d == StNullw) || (w_state_d == StErr);
    end

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_aq       <= '0;
            r_bq       <= '0;
            r_cq       <= '0;
            r_comp     <= 1'b0;
            r_sum_bin  <= '0;
            r_cout_bin <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_cin   <= w_cin_d;
            r_aq    <= w_aq_d;
            r_bq    <= w_bq_d;
            r_cq    <= w_cq_d;
            r_comp  <= w_comp_d;
            if (r_state == StData && w_state_d == StNullw) begin
                r_sum_bin  <= w_sum_dec;
                r_cout_bin <= w_car_s[1];
            end
        end
    end

    assign bus.in_ready   = (r_state == StIdle);
    assign bus.out_valid  = (r_state == StDone);
    assign bus.err        = (r_state == StErr);
    assign bus.aq         = r_aq;
    assign bus.bq         = r_bq;
    assign bus.cq         = r_cq;
    assign bus.sum_comp   = r_comp;
    assign bus.carry_comp = r_comp;
    assign bus.sum_bin    = r_sum_bin;
    assign bus.cout_bin   = r_cout_bin;

endmodule
